// File: rtl/mem_arbiter_if.sv
// Request and memory-side signals of the fetch/data memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface mem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_done, d_rdata,
    output m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_done, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port synchronous memory.
// Data has priority; a starve counter forces a fetch after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          CLK,
  input logic          Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StWait} state_e;

  localparam logic [2:0] LatInit   = 3'(MEM_LAT - 1);
  localparam logic [3:0] StarveTop = 4'(STARVE_MAX);

  state_e      r_state, w_state_d;
  logic [2:0]  r_lat_cnt, w_lat_cnt_d;
  logic [3:0]  r_starve, w_starve_d;
  logic        r_owner_f, w_owner_f_d;
  logic        r_f_rvalid, w_f_rvalid_d;
  logic        r_d_done, w_d_done_d;
  logic [31:0] r_f_rdata, w_f_rdata_d;
  logic [31:0] r_d_rdata, w_d_rdata_d;

  logic        w_pick_f;
  logic        w_f_gnt, w_d_gnt;
  logic        w_m_en, w_m_we;
  logic [31:0] w_m_addr, w_m_wdata;

  assign w_pick_f = bus.f_req & (~bus.d_req | (r_starve == StarveTop));

  always_comb begin
    w_state_d    = r_state;
    w_lat_cnt_d  = r_lat_cnt;
    w_owner_f_d  = r_owner_f;
    w_f_rvalid_d = 1'b0;
    w_d_done_d   = 1'b0;
    w_f_rdata_d  = r_f_rdata;
    w_d_rdata_d  = r_d_rdata;
    w_f_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_m_en       = 1'b0;
    w_m_we       = 1'b0;
    w_m_addr     = 32'd0;
    w_m_wdata    = 32'd0;
    unique case (r_state)
      StIdle: begin
        // No issue while reset is asserted so nothing reaches memory during reset.
        if (Reset && (bus.f_req || bus.d_req)) begin
          w_m_en      = 1'b1;
          w_lat_cnt_d = LatInit;
          if (w_pick_f) begin
            w_f_gnt     = 1'b1;
            w_m_addr    = bus.f_addr;
            w_owner_f_d = 1'b1;
            w_state_d   = StWait;
          end else begin
            w_d_gnt     = 1'b1;
            w_m_addr    = bus.d_addr;
            w_m_we      = bus.d_we;
            w_m_wdata   = bus.d_wdata;
            w_owner_f_d = 1'b0;
            if (bus.d_we) begin
              w_d_done_d = 1'b1;
            end else begin
              w_state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        if (r_lat_cnt == 3'd0) begin
          w_state_d = StIdle;
          if (r_owner_f) begin
            w_f_rdata_d  = bus.m_rdata;
            w_f_rvalid_d = 1'b1;
          end else begin
            w_d_rdata_d = bus.m_rdata;
            w_d_done_d  = 1'b1;
          end
        end else begin
          w_lat_cnt_d = r_lat_cnt - 3'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_starve_d = r_starve;
    if (!bus.f_req || w_f_gnt) begin
      w_starve_d = 4'd0;
    end else if (w_d_gnt && (r_starve != StarveTop)) begin
      w_starve_d = r_starve + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state    <= StIdle;
      r_lat_cnt  <= 3'd0;
      r_starve   <= 4'd0;
      r_owner_f  <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_done   <= 1'b0;
      r_f_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_state    <= w_state_d;
      r_lat_cnt  <= w_lat_cnt_d;
      r_starve   <= w_starve_d;
      r_owner_f  <= w_owner_f_d;
      r_f_rvalid <= w_f_rvalid_d;
      r_d_done   <= w_d_done_d;
      r_f_rdata  <= w_f_rdata_d;
      r_d_rdata  <= w_d_rdata_d;
    end
  end

  assign bus.f_gnt    = w_f_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.m_en     = w_m_en;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.f_rdata  = r_f_rdata;
  assign bus.d_done   = r_d_done;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.busy     = (r_state == StWait);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, read latency in cycles from memory enable to m_rdata valid (legal 1..4).
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while a fetch is pending (legal 1..15).
REQ-003 SHALL have ports CLK input 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have ports Reset input 1; one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports f_req in 1 (fetch request), f_addr in 32 (fetch address), f_gnt out 1 (fetch issued), f_rvalid out 1 (fetch data valid), f_rdata out 32 (fetched word).
REQ-006 SHALL have ports d_req in 1, d_we in 1 (1 = store), d_addr in 32, d_wdata in 32, d_gnt out 1, d_done out 1 (load data valid or store complete), d_rdata out 32.
REQ-007 SHALL have ports m_en out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_rdata in 32 (single-port synchronous memory).
REQ-008 SHALL have port busy out 1, high whenever a read is outstanding.

Function
REQ-009 SHALL implement FSM states IDLE and WAIT, with a 3-bit latency counter.
REQ-010 In IDLE with any request pending, SHALL issue exactly one access: m_en=1, drive m_addr/m_we/m_wdata from the winner, and pulse the winner's gnt for one cycle.
REQ-011 Arbitration: data wins over fetch, unless the starve counter equals STARVE_MAX and f_req=1, in which case fetch wins.
REQ-012 Starve counter: increments on each data grant while f_req=1; clears on fetch grant or on any cycle with f_req=0; saturates at STARVE_MAX.
REQ-013 Requesters hold req and the address/data stable until gnt; values changing before gnt are ignored, and the block samples them only in the grant cycle.
REQ-014 Fetch is always a read; m_we=0 and m_wdata=0 on fetch issue.
REQ-015 On a read issue at cycle T, SHALL enter WAIT, capture m_rdata at edge T+MEM_LAT into the winner's rdata register, and pulse the winner's rvalid/d_done in cycle T+MEM_LAT+1 alongside a return to IDLE.
REQ-016 A new access MAY issue in the same cycle as rvalid/d_done (back-to-back reads every MEM_LAT+1 cycles).
REQ-017 On a store issue at cycle T, SHALL stay in IDLE, pulse d_done in cycle T+1, and allow the next issue at T+1.
REQ-018 In WAIT, SHALL hold m_en=0 and keep all gnt signals low; requests stay pending.
REQ-019 f_rdata/d_rdata SHALL hold the last captured value until the next capture for that requester.
REQ-020 At most one access SHALL be outstanding; gnt, rvalid and done are single-cycle pulses.
REQ-021 When m_en=0, SHALL drive m_addr, m_wdata and m_we to 0.
REQ-022 busy SHALL equal (state==WAIT).

Reset
REQ-023 With Reset=0 at a rising edge, SHALL force state IDLE, clear the counters, and drive all outputs 0, including rdata registers.
REQ-024 Reset during WAIT SHALL discard the outstanding read; no rvalid/d_done for it after release.
REQ-025 In the first cycle after Reset returns to 1, SHALL arbitrate normally.

Verification
REQ-026 MEM_LAT=1 with f_req held at f_addr=0x40 and memory returning 0x8C010004 -> f_gnt at T, m_en=1 with m_addr=0x40 at T, f_rvalid at T+2 with f_rdata=0x8C010004.
REQ-027 f_req and d_req rise together with d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> d_gnt at T with m_we=1; d_done at T+1; f_gnt at T+1.
REQ-028 STARVE_MAX=4 with d_req and f_req held continuously on stores -> exactly 4 d_gnt, then f_gnt, then the pattern repeats.
REQ-029 MEM_LAT=3 with a load at T -> busy high T+1..T+3; no gnt during T+1..T+3; d_done at T+4 with the captured word.
REQ-030 Reset low at T+1 after a read issue at T -> outputs 0; no f_rvalid afterwards; the next request after release is granted in the first cycle.
